// File: rtl/keypad_emulator_pkg.sv
// kp_pkg: shared definitions for the 4x4 keypad emulator and any scanner that
// needs to decode key_code the same way.
//   kp_state_e     : FSM state encodings
//   KP_ROW_IDLE    : row/column value meaning "nothing asserted"
//   KP_*_LSB/IDX_W : key_code field positions, code = {col[1:0], row[1:0]}
//   kp_onehot_low  : index -> active-low one-hot line pattern
package kp_pkg;

  typedef enum logic [1:0] {
    KP_IDLE    = 2'd0,
    KP_PRESS   = 2'd1,
    KP_RELEASE = 2'd2
  } kp_state_e;

  localparam logic [3:0] KP_ROW_IDLE = 4'b1111;

  localparam int KP_IDX_W   = 2;
  localparam int KP_COL_LSB = 2;
  localparam int KP_ROW_LSB = 0;

  function automatic logic [3:0] kp_onehot_low(input logic [KP_IDX_W-1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: request handshake plus the scan lines of the keypad.
//   key_valid/key_code : press request from the requester (master)
//   key_ready          : emulator idle and able to take a request
//   shift_col          : active-low column strobes from the scanner (master)
//   row                : active-low row sense lines back to the scanner
//   busy/done/timeout  : emulator status
// master = requester/scanner side, slave = keypad emulator.
interface keypad_emulator_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] shift_col;
  logic [3:0] row;
  logic       busy;
  logic       done;
  logic       timeout;

  modport master (
    output key_valid, key_code, shift_col,
    input  key_ready, row, busy, done, timeout
  );

  modport slave (
    input  key_valid, key_code, shift_col,
    output key_ready, row, busy, done, timeout
  );
endinterface

// File: rtl/keypad_emulator_strobe_counter.sv
// kp_strobe_counter: detects the trailing edge of a strobe (match was high
// last cycle, low now) and counts those edges up to LIMIT, saturating.
//   clk, reset : clock, async active-high reset
//   match      : strobe currently active
//   clear      : hold the count at zero
//   strobe_end : combinational, trailing edge seen this cycle
//   reach      : combinational, this edge is the LIMIT-th one
module kp_strobe_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic match,
  input  logic clear,
  output logic strobe_end,
  output logic reach
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM    = CW'(LIMIT);
  localparam logic [CW-1:0] LIM_M1 = CW'(LIMIT - 1);

  logic          match_q;
  logic [CW-1:0] cnt;

  assign strobe_end = match_q && !match;
  assign reach      = strobe_end && (cnt >= LIM_M1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q <= 1'b0;
      cnt     <= '0;
    end else begin
      match_q <= match;
      if (clear) begin
        cnt <= '0;
      end else if (strobe_end && (cnt != LIM)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: passive 4x4 matrix-keypad responder. Accepts one key per
// handshake, answers the scanner's column strobes with that key's row
// pattern for HOLD_SCANS target strobes, then releases for GAP_SCANS
// column-0 strobes before taking the next key.
//   clk, reset : clock, async active-high reset
//   bus        : keypad_emulator_if.slave (handshake, scan lines, status)
//
// state      | meaning
// KP_IDLE    | key_ready high, waiting for a request
// KP_PRESS   | key held; row answers target-column strobes
// KP_RELEASE | key up; waiting for column-0 strobes before re-arming
module keypad_emulator
  import kp_pkg::*;
#(
  parameter int HOLD_SCANS = 4,
  parameter int GAP_SCANS  = 2,
  parameter int TIMEOUT    = 1023
) (
  input logic             clk,
  input logic             reset,
  keypad_emulator_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);

  kp_state_e     state;
  logic [3:0]    code_q;
  logic [TW-1:0] cyc_cnt;

  logic [KP_IDX_W-1:0] col_idx;
  logic [KP_IDX_W-1:0] row_idx;
  logic tgt_act, col0_act;
  logic hold_match, hold_clear, hold_se, hold_reach;
  logic gap_match, gap_clear, gap_se, gap_reach;
  logic expire;

  assign col_idx = code_q[KP_COL_LSB +: KP_IDX_W];
  assign row_idx = code_q[KP_ROW_LSB +: KP_IDX_W];

  // Exact compare: idle (1111) or multi-low strobes never match.
  assign tgt_act  = (bus.shift_col == kp_onehot_low(col_idx));
  assign col0_act = (bus.shift_col == kp_onehot_low('0));

  assign hold_match = (state == KP_PRESS) && tgt_act;
  assign hold_clear = (state != KP_PRESS);
  assign gap_match  = (state == KP_RELEASE) && col0_act;
  assign gap_clear  = (state != KP_RELEASE);

  kp_strobe_counter #(.LIMIT(HOLD_SCANS)) u_hold (
    .clk        (clk),
    .reset      (reset),
    .match      (hold_match),
    .clear      (hold_clear),
    .strobe_end (hold_se),
    .reach      (hold_reach)
  );

  kp_strobe_counter #(.LIMIT(GAP_SCANS)) u_gap (
    .clk        (clk),
    .reset      (reset),
    .match      (gap_match),
    .clear      (gap_clear),
    .strobe_end (gap_se),
    .reach      (gap_reach)
  );

  // One watchdog serves both PRESS and RELEASE; it restarts on every
  // counted strobe end of whichever counter is active.
  assign expire = (cyc_cnt == TO_LAST);

  // Row follows shift_col with no register, as a physical key switch would.
  assign bus.row = ((state == KP_PRESS) && tgt_act) ? kp_onehot_low(row_idx) : KP_ROW_IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= KP_IDLE;
      code_q        <= '0;
      cyc_cnt       <= '0;
      bus.key_ready <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.timeout   <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.timeout <= 1'b0;
      case (state)
        KP_IDLE: begin
          bus.key_ready <= 1'b1;
          bus.busy      <= 1'b0;
          cyc_cnt       <= '0;
          if (bus.key_valid && bus.key_ready) begin
            code_q        <= bus.key_code;
            state         <= KP_PRESS;
            bus.key_ready <= 1'b0;
            bus.busy      <= 1'b1;
          end
        end
        KP_PRESS: begin
          if (hold_se && hold_reach) begin
            state    <= KP_RELEASE;
            bus.done <= 1'b1;
            cyc_cnt  <= '0;
          end else if (hold_se) begin
            cyc_cnt <= '0;
          end else if (expire) begin
            state       <= KP_RELEASE;
            bus.timeout <= 1'b1;
            cyc_cnt     <= '0;
          end else if (cyc_cnt != TO_MAX) begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        KP_RELEASE: begin
          if ((gap_se && gap_reach) || (!gap_se && expire)) begin
            state         <= KP_IDLE;
            bus.key_ready <= 1'b1;
            bus.busy      <= 1'b0;
            cyc_cnt       <= '0;
          end else if (gap_se) begin
            cyc_cnt <= '0;
          end else if (cyc_cnt != TO_MAX) begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        default: begin
          state         <= KP_IDLE;
          bus.key_ready <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

  localparam int EV_DONE = 1;
  localparam int EV_TMO  = 2;
  localparam int EV_RDY  = 3;

  typedef struct {
    int kind;
    int lat;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  keypad_emulator_if kif0();
  keypad_emulator_if kif1();

  keypad_emulator #(.HOLD_SCANS(4), .GAP_SCANS(2), .TIMEOUT(63)) dut0 (
    .clk   (clk),
    .reset (rst),
    .bus   (kif0)
  );

  keypad_emulator #(.HOLD_SCANS(4), .GAP_SCANS(2), .TIMEOUT(15)) dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (kif1)
  );

  always #5 clk = ~clk;

  ev_t        ev_q0[$];
  ev_t        ev_q1[$];
  logic [3:0] row_q0[$];
  logic [3:0] row_q1[$];

  int checks = 0;
  int errors = 0;
  int cyc[2];
  bit armed[2];
  bit rdy_q[2];

  task automatic check(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d actual %0h required %0h (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  function automatic void push_ev(input int d, input int kind, input int lat);
    ev_t e;
    e.kind = kind;
    e.lat  = lat;
    if (d == 0) ev_q0.push_back(e);
    else        ev_q1.push_back(e);
  endfunction

  function automatic void push_row(input int d, input logic [3:0] r);
    if (d == 0) row_q0.push_back(r);
    else        row_q1.push_back(r);
  endfunction

  task automatic take_event(input int d, input int kind, input string name);
    ev_t e;
    bit  got = 0;
    if (d == 0 && ev_q0.size() > 0) begin
      e = ev_q0.pop_front();
      got = 1;
    end else if (d == 1 && ev_q1.size() > 0) begin
      e = ev_q1.pop_front();
      got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s dut%0d actual unexpected kind %0d at cycle %0d required none", name, d, kind, cyc[d]);
    end else begin
      check({name, "_kind"}, d, kind, e.kind);
      check({name, "_latency"}, d, cyc[d], e.lat);
    end
  endtask

  // Monitor: one call per DUT per falling edge.
  task automatic mon(input int d, input logic dn, input logic tm, input logic rdy,
                     input logic vld, input logic [3:0] rw);
    logic [3:0] er;
    cyc[d]++;
    if (rst) begin
      armed[d] = 0;
    end else begin
      if (d == 0 && row_q0.size() > 0) begin
        er = row_q0.pop_front();
        check("row", d, rw, er);
      end else if (d == 1 && row_q1.size() > 0) begin
        er = row_q1.pop_front();
        check("row", d, rw, er);
      end
      if (dn || tm) take_event(d, dn ? EV_DONE : EV_TMO, "pulse");
      if (rdy && !rdy_q[d] && armed[d]) take_event(d, EV_RDY, "ready");
      if (vld && rdy) begin
        cyc[d]   = -1;
        armed[d] = 1;
      end
    end
    rdy_q[d] = rdy;
  endtask

  always @(negedge clk) begin
    mon(0, kif0.done, kif0.timeout, kif0.key_ready, kif0.key_valid, kif0.row);
    mon(1, kif1.done, kif1.timeout, kif1.key_ready, kif1.key_valid, kif1.row);
  end

  task automatic set_in(input int d, input logic v, input logic [3:0] code, input logic [3:0] sc);
    if (d == 0) begin
      kif0.key_valid = v;
      kif0.key_code  = code;
      kif0.shift_col = sc;
    end else begin
      kif1.key_valid = v;
      kif1.key_code  = code;
      kif1.shift_col = sc;
    end
  endtask

  task automatic drive_cycle(input int d, input logic v, input logic [3:0] code,
                             input logic [3:0] sc, input logic [3:0] exp_row);
    @(posedge clk);
    #1;
    set_in(d, v, code, sc);
    push_row(d, exp_row);
  endtask

  task automatic press(input int d, input logic [3:0] code);
    int n = 0;
    @(posedge clk);
    #1;
    while (!(d == 0 ? kif0.key_ready : kif1.key_ready) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL ready_wait dut%0d actual key_ready low for %0d cycles required high", d, n);
    end
    set_in(d, 1'b1, code, 4'b1111);
    push_row(d, 4'b1111);
  endtask

  // Scanner: pre cycles of malformed/idle columns, then 4 cycles per column.
  task automatic run_scan(input int d, input int pre, input int ncyc,
                          input logic [3:0] tgt, input logic [3:0] pat, input int press_end,
                          input logic v, input logic [3:0] code);
    for (int t = 0; t < ncyc; t++) begin
      logic [3:0] sc;
      logic [3:0] er;
      if (t < pre) sc = (t < pre / 2) ? 4'b1100 : 4'b1111;
      else         sc = ~(4'b0001 << (((t - pre) / 4) % 4));
      er = (t < press_end && sc == tgt) ? pat : 4'b1111;
      drive_cycle(d, v, code, sc, er);
    end
  endtask

  initial begin
    logic [3:0] code, tgt, pat;
    int         col;
    set_in(0, 1'b0, 4'h0, 4'b1111);
    set_in(1, 1'b0, 4'h0, 4'b1111);
    repeat (3) @(posedge clk);
    #1;
    check("rst_row", 0, kif0.row, 4'b1111);
    check("rst_ready", 0, kif0.key_ready, 0);
    check("rst_busy", 0, kif0.busy, 0);
    check("rst_done", 0, kif0.done, 0);
    check("rst_timeout", 0, kif0.timeout, 0);
    check("rst_row", 1, kif1.row, 4'b1111);
    rst = 1'b0;

    // Code 6: col1/row2
    push_ev(0, EV_DONE, 57);
    push_ev(0, EV_RDY, 85);
    press(0, 4'h6);
    run_scan(0, 0, 96, 4'b1101, 4'b1011, 57, 1'b0, 4'h6);

    // All 16 codes
    for (int c = 0; c < 16; c++) begin
      code = 4'(c);
      col  = c / 4;
      tgt  = ~(4'b0001 << col);
      pat  = ~(4'b0001 << (c % 4));
      push_ev(0, EV_DONE, 53 + 4 * col);
      push_ev(0, EV_RDY, 85);
      press(0, code);
      run_scan(0, 0, 96, tgt, pat, 53 + 4 * col, 1'b0, code);
    end

    // No strobes at all: watchdog in PRESS then RELEASE
    push_ev(1, EV_TMO, 15);
    push_ev(1, EV_RDY, 30);
    press(1, 4'h0);
    repeat (40) drive_cycle(1, 1'b0, 4'h0, 4'b1111, 4'b1111);

    // Malformed 1100 then idle before real scans
    push_ev(0, EV_DONE, 61);
    push_ev(0, EV_RDY, 93);
    press(0, 4'h0);
    run_scan(0, 8, 104, 4'b1110, 4'b1110, 61, 1'b0, 4'h0);

    // key_valid held with 3 then 9
    push_ev(0, EV_DONE, 53);
    push_ev(0, EV_RDY, 85);
    push_ev(0, EV_DONE, 61);
    push_ev(0, EV_RDY, 85);
    press(0, 4'h3);
    run_scan(0, 0, 86, 4'b1110, 4'b0111, 53, 1'b1, 4'h9);
    run_scan(0, 0, 96, 4'b1011, 4'b1101, 61, 1'b0, 4'h9);

    // Reset in the middle of a press
    press(0, 4'h5);
    repeat (3) drive_cycle(0, 1'b0, 4'h5, 4'b1101, 4'b1101);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_row", 0, kif0.row, 4'b1111);
    check("midrst_busy", 0, kif0.busy, 0);
    check("midrst_done", 0, kif0.done, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) drive_cycle(0, 1'b0, 4'h5, 4'b1101, 4'b1111);
    check("postrst_busy", 0, kif0.busy, 0);
    check("postrst_ready", 0, kif0.key_ready, 1);

    repeat (4) @(posedge clk);
    #1;
    check("events_left", 0, ev_q0.size(), 0);
    check("events_left", 1, ev_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
